// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the multi-channel RAM port arbiter.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam logic RD = 1'b0;
    localparam logic WR = 1'b1;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/ram_port_arbiter_rr_arbiter.sv
// Combinational winner select: round-robin from ptr, or fixed priority (lowest index wins).
module rr_arbiter #(
    parameter int NUM_CH  = 4,
    parameter int RR_MODE = 1,
    parameter int ID_W    = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [ID_W-1:0]   ptr,
    output logic [ID_W-1:0]   winner,
    output logic              valid
);

    logic [ID_W-1:0] slot;

    // Scan from the far end toward the highest-priority slot so the last hit wins.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        slot   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (RR_MODE != 0) begin
                slot = ID_W'((int'(ptr) + i) % NUM_CH);
            end else begin
                slot = ID_W'(i);
            end
            if (req[slot]) begin
                winner = slot;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Multi-channel RAM access controller: one RAM transaction at a time, strobe/done handshake.
// Optional watchdog on the RAM done handshake is enabled by defining ARB_TIMEOUT_EN.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RR_MODE = 1,
`ifdef ARB_TIMEOUT_EN
    parameter int TIMEOUT_CYC = 255,
`endif
    localparam int ID_W = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     RST,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH-1:0]        ch_write,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
    output logic [NUM_CH-1:0]        ch_done,
    output logic [DATA_W-1:0]        ch_rdata,
    output logic                     busy,
    output logic [ID_W-1:0]          grant_id,
    output logic [ADDR_W-1:0]        ram_address,
    output logic [DATA_W-1:0]        ram_data_in,
    output logic                     ram_read,
    output logic                     ram_write,
`ifdef ARB_TIMEOUT_EN
    output logic                     timeout_err,
`endif
    input  logic [DATA_W-1:0]        ram_data_out,
    input  logic                     ram_done_read,
    input  logic                     ram_done_write
);

    arb_state_t      state;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] win_id;
    logic            win_valid;
    logic            lat_write;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic            matched_done;
`ifdef ARB_TIMEOUT_EN
    logic [31:0]     timer;
`endif

    rr_arbiter #(
        .NUM_CH  (NUM_CH),
        .RR_MODE (RR_MODE),
        .ID_W    (ID_W)
    ) u_arb (
        .req    (ch_req),
        .ptr    (ptr),
        .winner (win_id),
        .valid  (win_valid)
    );

    // Only the done that matches the latched direction may complete the transfer.
    assign matched_done = (lat_write == WR) ? ram_done_write : ram_done_read;

    assign ch_done = (state == RESP) ? (NUM_CH'(1) << grant_id) : '0;

    always_ff @(posedge clk) begin
        if (RST) begin
            state       <= IDLE;
            ptr         <= '0;
            grant_id    <= '0;
            lat_write   <= RD;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            busy        <= 1'b0;
            ch_rdata    <= '0;
            ram_address <= '0;
            ram_data_in <= '0;
            ram_read    <= 1'b0;
            ram_write   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            timer       <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        grant_id  <= win_id;
                        lat_write <= ch_write[win_id];
                        lat_addr  <= ch_addr[int'(win_id)*ADDR_W +: ADDR_W];
                        lat_wdata <= ch_wdata[int'(win_id)*DATA_W +: DATA_W];
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    ram_address <= lat_addr;
                    ram_data_in <= lat_wdata;
                    ram_read    <= (lat_write == RD);
                    ram_write   <= (lat_write == WR);
`ifdef ARB_TIMEOUT_EN
                    timer       <= '0;
`endif
                    state       <= WAIT;
                end
                WAIT: begin
                    if (matched_done) begin
                        ram_read  <= 1'b0;
                        ram_write <= 1'b0;
                        busy      <= 1'b0;
                        if (lat_write == RD) begin
                            ch_rdata <= ram_data_out;
                        end
                        state     <= RESP;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (timer >= 32'(TIMEOUT_CYC - 1)) begin
                        ram_read    <= 1'b0;
                        ram_write   <= 1'b0;
                        busy        <= 1'b0;
                        if (lat_write == RD) begin
                            ch_rdata <= '1;
                        end
                        timeout_err <= 1'b1;
                        state       <= RESP;
                    end else begin
                        timer <= timer + 32'd1;
                    end
`endif
                end
                RESP: begin
                    if (RR_MODE != 0) begin
                        ptr <= (grant_id == ID_W'(NUM_CH - 1)) ? '0 : grant_id + 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: scoreboard of expected completions plus a fixed-priority instance.
module tb_ram_port_arbiter;

    localparam int NUM_CH = 4;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int ID_W   = 2;
    localparam int EW     = 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NUM_CH-1:0]        ch_req;
    logic [NUM_CH-1:0]        ch_write;
    logic [NUM_CH*ADDR_W-1:0] ch_addr;
    logic [NUM_CH*DATA_W-1:0] ch_wdata;
    logic [NUM_CH-1:0]        ch_done;
    logic [DATA_W-1:0]        ch_rdata;
    logic                     busy;
    logic [ID_W-1:0]          grant_id;
    logic [ADDR_W-1:0]        ram_address;
    logic [DATA_W-1:0]        ram_data_in;
    logic                     ram_read;
    logic                     ram_write;
    logic [DATA_W-1:0]        ram_data_out;
    logic                     ram_done_read;
    logic                     ram_done_write;
`ifdef ARB_TIMEOUT_EN
    logic                     timeout_err;
    logic                     fp_timeout_err;
`endif

    logic [NUM_CH-1:0]        fp_req;
    logic [NUM_CH-1:0]        fp_done;
    logic [DATA_W-1:0]        fp_rdata;
    logic                     fp_busy;
    logic [ID_W-1:0]          fp_grant_id;
    logic [ADDR_W-1:0]        fp_ram_address;
    logic [DATA_W-1:0]        fp_ram_data_in;
    logic                     fp_ram_read;
    logic                     fp_ram_write;
    logic                     fp_ram_done_read;
    logic                     fp_ram_done_write;

    ram_port_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RR_MODE(1)) dut (
        .clk(clk), .RST(rst), .ch_req(ch_req), .ch_write(ch_write), .ch_addr(ch_addr),
        .ch_wdata(ch_wdata), .ch_done(ch_done), .ch_rdata(ch_rdata), .busy(busy),
        .grant_id(grant_id), .ram_address(ram_address), .ram_data_in(ram_data_in),
        .ram_read(ram_read), .ram_write(ram_write),
`ifdef ARB_TIMEOUT_EN
        .timeout_err(timeout_err),
`endif
        .ram_data_out(ram_data_out), .ram_done_read(ram_done_read), .ram_done_write(ram_done_write)
    );

    ram_port_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RR_MODE(0)) dut_fp (
        .clk(clk), .RST(rst), .ch_req(fp_req), .ch_write(ch_write), .ch_addr(ch_addr),
        .ch_wdata(ch_wdata), .ch_done(fp_done), .ch_rdata(fp_rdata), .busy(fp_busy),
        .grant_id(fp_grant_id), .ram_address(fp_ram_address), .ram_data_in(fp_ram_data_in),
        .ram_read(fp_ram_read), .ram_write(fp_ram_write),
`ifdef ARB_TIMEOUT_EN
        .timeout_err(fp_timeout_err),
`endif
        .ram_data_out(8'h00), .ram_done_read(fp_ram_done_read), .ram_done_write(fp_ram_done_write)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [EW-1:0] exp_q[$];
    int pending [NUM_CH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // RAM model: done after 'lat' strobe cycles (lat=0 never completes);
    // wrong_done injects a write-done on the first cycle of a read.
    int  lat        = 1;
    bit  wrong_done = 0;
    int  ram_cyc    = 0;
    logic [7:0] mem [logic [15:0]];

    always @(negedge clk) begin
        if (ram_read || ram_write) begin
            ram_cyc++;
            ram_done_read  = ram_read  && lat != 0 && ram_cyc == lat;
            ram_done_write = ram_write && lat != 0 && ram_cyc == lat;
            if (ram_read)
                ram_data_out = mem.exists(ram_address) ? mem[ram_address] : 8'h00;
            if (ram_write && ram_done_write)
                mem[ram_address] = ram_data_in;
            if (wrong_done && ram_read && ram_cyc == 1)
                ram_done_write = 1'b1;
        end else begin
            ram_cyc        = 0;
            ram_done_read  = 1'b0;
            ram_done_write = 1'b0;
        end
        fp_ram_done_read  = fp_ram_read;
        fp_ram_done_write = fp_ram_write;
    end

    int rd_cycles, wr_cycles, wr_bad;
    logic [15:0] exp_waddr;
    logic [7:0]  exp_wdata;
    logic [EW-1:0] mon_e;
    logic [3:0]    mon_exp_done;
    int fp_cnt [NUM_CH];
    int fp_bad_grant;

    // Monitor: pops the scoreboard on every completion pulse and releases finished clients.
    always @(negedge clk) begin
        if (ram_read) rd_cycles++;
        if (ram_write) begin
            wr_cycles++;
            if (ram_address !== exp_waddr || ram_data_in !== exp_wdata) wr_bad++;
        end
        if (ch_done != '0) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: ch_done=%b with no completion expected", ch_done);
            end else begin
                mon_e        = exp_q.pop_front();
                mon_exp_done = 4'(1) << mon_e[11:9];
                check("done_channel", {28'd0, ch_done}, {28'd0, mon_exp_done});
                if (mon_e[8]) check("read_data", {24'd0, ch_rdata}, {24'd0, mon_e[7:0]});
            end
            for (int k = 0; k < NUM_CH; k++) begin
                if (ch_done[k] && pending[k] > 0) begin
                    pending[k]--;
                    if (pending[k] == 0) ch_req[k] = 1'b0;
                end
            end
        end
        for (int k = 0; k < NUM_CH; k++) if (fp_done[k]) fp_cnt[k]++;
        if (fp_busy && fp_grant_id != 2'd1) fp_bad_grant++;
    end

    task automatic push_exp(input int k, input logic is_read, input logic [7:0] d);
        exp_q.push_back({3'(k), is_read, d});
    endtask

    task automatic set_ch(input int k, input logic wr, input logic [15:0] a,
                          input logic [7:0] d, input int n);
        ch_write[k]                = wr;
        ch_addr[k*ADDR_W +: ADDR_W] = a;
        ch_wdata[k*DATA_W +: DATA_W] = d;
        pending[k]                 = n;
        ch_req[k]                  = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || ch_req != '0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, {31'd0, (exp_q.size() == 0 && ch_req == '0)}, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        ch_req = '0;
        fp_req = '0;
        for (int k = 0; k < NUM_CH; k++) pending[k] = 0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; ch_req = '0; fp_req = '0; ch_write = '0; ch_addr = '0; ch_wdata = '0;
        ram_data_out = '0; ram_done_read = 1'b0; ram_done_write = 1'b0;
        fp_ram_done_read = 1'b0; fp_ram_done_write = 1'b0;
        rd_cycles = 0; wr_cycles = 0; wr_bad = 0; exp_waddr = '0; exp_wdata = '0;
        fp_bad_grant = 0;
        for (int k = 0; k < NUM_CH; k++) begin pending[k] = 0; fp_cnt[k] = 0; end
        mem[16'h0010] = 8'hA5;
        mem[16'h0020] = 8'h5A;
        mem[16'h0050] = 8'hC3;
        for (int k = 0; k < NUM_CH; k++) mem[16'h0100 + 16'(k)] = 8'h10 + 8'(k);

        // Reset values
        do_reset();
        check("rst_ch_done",  {28'd0, ch_done}, 32'd0);
        check("rst_busy",     {31'd0, busy}, 32'd0);
        check("rst_grant_id", {30'd0, grant_id}, 32'd0);
        check("rst_strobes",  {30'd0, ram_read, ram_write}, 32'd0);
        check("rst_ram_addr", {16'd0, ram_address}, 32'd0);
        check("rst_data",     {16'd0, ram_data_in, ch_rdata}, 32'd0);

        // Single read: channel 2 reads 0x0010, done three strobe cycles in
        lat = 3; rd_cycles = 0;
        push_exp(2, 1'b1, 8'hA5);
        set_ch(2, 1'b0, 16'h0010, 8'h00, 1);
        @(negedge clk);
        check("rd_strobe_not_yet", {31'd0, ram_read}, 32'd0);
        check("rd_busy",           {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("rd_strobe_cycle2",  {31'd0, ram_read}, 32'd1);
        check("rd_grant_id",       {30'd0, grant_id}, 32'd2);
        check("rd_address",        {16'd0, ram_address}, 32'h0010);
        wait_drain("single_read");
        check("rd_strobe_width",   rd_cycles, 32'd3);

        // Single write: channel 0 writes 0x3C to 0xFFFF
        lat = 2; wr_cycles = 0; wr_bad = 0; rd_cycles = 0;
        exp_waddr = 16'hFFFF; exp_wdata = 8'h3C;
        push_exp(0, 1'b0, 8'h00);
        set_ch(0, 1'b1, 16'hFFFF, 8'h3C, 1);
        wait_drain("single_write");
        check("wr_strobe_width", wr_cycles, 32'd2);
        check("wr_addr_data",    wr_bad, 32'd0);
        check("wr_no_read",      rd_cycles, 32'd0);
        check("wr_mem",          {24'd0, mem[16'hFFFF]}, 32'h3C);

        // Mismatched done during a read is ignored
        lat = 4; wrong_done = 1; rd_cycles = 0;
        push_exp(1, 1'b1, 8'h5A);
        set_ch(1, 1'b0, 16'h0020, 8'h00, 1);
        wait_drain("mismatch_done");
        wrong_done = 0;
        check("mismatch_strobe_width", rd_cycles, 32'd4);

        // Round-robin fairness: all four request continuously, two rounds
        do_reset();
        lat = 1;
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < NUM_CH; k++) push_exp(k, 1'b1, 8'h10 + 8'(k));
        for (int k = 0; k < NUM_CH; k++) set_ch(k, 1'b0, 16'h0100 + 16'(k), 8'h00, 2);
        wait_drain("round_robin");

        // Fixed priority: channels 1 and 3 request continuously on the RR_MODE=0 instance
        do_reset();
        for (int k = 0; k < NUM_CH; k++) fp_cnt[k] = 0;
        fp_bad_grant = 0;
        fp_req = 4'b1010;
        for (int n = 0; n < 200 && fp_cnt[1] < 5; n++) @(negedge clk);
        fp_req = '0;
        repeat (10) @(negedge clk);
        check("fp_ch1_served",  {31'd0, (fp_cnt[1] >= 5)}, 32'd1);
        check("fp_ch3_starved", fp_cnt[3], 32'd0);
        check("fp_grant_ch1",   fp_bad_grant, 32'd0);

        // Reset mid-WAIT aborts the read and returns the pointer to 0
        do_reset();
        lat = 1;
        push_exp(1, 1'b0, 8'h00);
        set_ch(1, 1'b1, 16'h0030, 8'h77, 1);
        wait_drain("pre_reset_write");
        lat = 0;
        set_ch(3, 1'b0, 16'h0040, 8'h00, 1);
        for (int n = 0; n < 20 && !ram_read; n++) @(negedge clk);
        check("hang_strobe_up", {31'd0, ram_read}, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        ch_req = '0;
        for (int k = 0; k < NUM_CH; k++) pending[k] = 0;
        @(negedge clk);
        check("abort_strobe_low", {30'd0, ram_read, ram_write}, 32'd0);
        check("abort_busy",       {31'd0, busy}, 32'd0);
        check("abort_no_done",    {28'd0, ch_done}, 32'd0);
        rst = 1'b0;
        lat = 1;
        push_exp(0, 1'b1, 8'hC3);
        push_exp(2, 1'b1, 8'hA5);
        set_ch(2, 1'b0, 16'h0010, 8'h00, 1);
        set_ch(0, 1'b0, 16'h0050, 8'h00, 1);
        wait_drain("after_abort");
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Parametrised multi-channel RAM access controller: the next generation of the single-client DMA path between processing modules (decompress handler, loader, CNN engine) and the shared RAM.
- Accepts read/write requests from NUM_CH client channels and arbitrates them round-robin or fixed-priority.
- Issues exactly one RAM transaction at a time using the RAM's read/write strobe and done handshake.
- Returns read data and a one-cycle done pulse to the owning channel.

Parameters:
- NUM_CH, 4, number of client channels (2..8).
- ADDR_W, 16, RAM address width.
- DATA_W, 8, RAM data width.
- RR_MODE, 1, 1 = round-robin arbitration; 0 = fixed priority with channel 0 highest.

Ports:
- clk  in  1  single system clock; all logic is on the rising edge.
- RST  in  1  synchronous, active-high reset.
- ch_req  in  NUM_CH  per-channel request. Must be held high until that channel's done pulse.
- ch_write  in  NUM_CH  per-channel direction: 1 = write, 0 = read.
- ch_addr  in  NUM_CH*ADDR_W  packed per-channel address; channel k occupies bits [k*ADDR_W +: ADDR_W].
- ch_wdata  in  NUM_CH*DATA_W  packed per-channel write data.
- ch_done  out  NUM_CH  one-cycle completion pulse to the owning channel.
- ch_rdata  out  DATA_W  read data. Valid on the cycle ch_done pulses for a read, and held until the next read completes.
- busy  out  1  high while a transaction is in flight.
- grant_id  out  $clog2(NUM_CH)  index of the channel currently owning the RAM.
- ram_address  out  ADDR_W  RAM address.
- ram_data_in  out  DATA_W  data written to RAM.
- ram_read  out  1  RAM read strobe, held until ram_done_read.
- ram_write  out  1  RAM write strobe, held until ram_done_write.
- ram_data_out  in  DATA_W  RAM read data. Sampled when ram_done_read is high.
- ram_done_read  in  1  RAM read complete.
- ram_done_write  in  1  RAM write complete.

Behaviour:
- Reset values: all outputs 0; round-robin pointer 0; state IDLE.
- Reset taken at any point, including mid-transaction, aborts the transaction. Strobes are low from the next edge and no ch_done is issued.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any ch_req is high, select the winner and latch its id, direction, address and write data.
  - busy goes high; next state is ISSUE.
  - Round-robin: the winner is the first requesting channel at or after the pointer, scanning upward and wrapping from NUM_CH-1 to 0.
  - Fixed priority: the winner is the lowest-index requester.
- ISSUE: drive ram_address and ram_data_in from the latched values. Assert ram_read or ram_write. Next state is WAIT. First strobe appears 2 cycles after the request is seen.
- WAIT:
  - Hold the strobe and address stable.
  - For a read, only ram_done_read completes the transaction; for a write, only ram_done_write. A non-matching done is ignored.
  - On completion: deassert the strobe on the same edge and register ram_data_out into ch_rdata for reads. Next state is RESP.
- RESP:
  - Pulse ch_done[grant_id] for exactly one cycle; busy goes low.
  - In RR_MODE, the pointer becomes (grant_id+1) mod NUM_CH.
  - Next state is IDLE. Back-to-back transactions on a new grant start at the following edge.
- Requests that change while another channel is granted do not disturb the latched transaction.
- A channel that drops ch_req before its done is a protocol violation; the transaction still completes normally.
- Minimum turnaround is 4 cycles per transaction when RAM done arrives the cycle after the strobe.
- Minimum-width ID: for NUM_CH=2 the grant_id width is 1.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - Adds parameter TIMEOUT_CYC, default 255, and output port timeout_err (1 bit, reset 0).
  - A counter runs in WAIT. If TIMEOUT_CYC cycles elapse without a matching done, the strobe is dropped and the FSM moves to RESP.
  - ch_done still pulses; for reads ch_rdata is forced to all-ones.
  - timeout_err is set sticky until RST.
- When undefined: no counter and no timeout_err port; WAIT lasts indefinitely.

Decomposition:
- Shared package ram_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP);
  - the direction constants RD=0 and WR=1;
  - default widths ADDR_W_DEF=16 and DATA_W_DEF=8.
- One sub-module: rr_arbiter. It is combinational winner select from a request vector plus pointer, outputting a winner index and a valid flag, and handles both RR_MODE values.

Test Plan:
- Single read: channel 2 reads 0x0010, RAM returns 0xA5 with ram_done_read 3 cycles after the strobe -> ram_read high for exactly 3 cycles; ch_done[2] pulses once; ch_rdata = 0xA5.
- Single write: channel 0 writes 0x3C to 0xFFFF -> ram_write high, ram_address = 0xFFFF, ram_data_in = 0x3C; ch_done[0] pulses once after ram_done_write.
- Round-robin fairness: all 4 channels request continuously, RR_MODE=1 -> grant order 0,1,2,3,0; no channel is granted twice before the others are served.
- Fixed priority: RR_MODE=0, channels 1 and 3 request continuously -> channel 1 is always granted and channel 3 starves.
- Mismatched done: during a read, ram_done_write pulses -> ignored, read stays pending; a later ram_done_read completes it.
- Reset mid-WAIT: RST asserted while ram_read is high -> ram_read low at the next edge; no ch_done; busy = 0; the next request is granted to channel 0 in RR_MODE.
